// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order imem requests and buffers
// responses with their PC for Decode. Define FETCH_PERF_CNT_EN to build the stall_cnt counter.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] stall_cnt
);

  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q;
  logic [CW-1:0] outstanding_q, outstanding_d, drop_q, fifo_count_q, credits_used;
  logic [PW-1:0] aq_wr_q, aq_rd_q, fifo_wr_q, fifo_rd_q;
  logic [31:0]   aq_mem    [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_word [FIFO_DEPTH];
  logic          issue, rsp, drop_rsp, push, pop, redirect;
  logic          unused_pc_bits;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (halt) state_d = HALTED;
      HALTED:  if (!halt) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Credits cover both in-flight requests and buffered words, so a response always has a slot.
  assign credits_used  = outstanding_q + fifo_count_q;
  assign imem_req      = (state_q == RUN) && (credits_used < DEPTH_C);
  assign imem_addr     = pc_q;
  assign issue         = imem_req && imem_gnt;
  assign rsp           = imem_rvalid && (outstanding_q != '0);
  assign drop_rsp      = rsp && (drop_q != '0);
  assign redirect      = redirect_valid && (state_q != IDLE);
  assign push          = rsp && !drop_rsp && !redirect;
  assign pop           = instr_valid && instr_ready;
  assign outstanding_d = outstanding_q + CW'(issue) - CW'(rsp);
  assign unused_pc_bits = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      aq_wr_q       <= '0;
      aq_rd_q       <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (redirect)   pc_q <= {redirect_pc[31:2], 2'b00};
      else if (issue) pc_q <= pc_q + 32'd4;
      // Pending drops are still counted in outstanding, so this accumulates across redirects.
      if (redirect)      drop_q <= outstanding_d;
      else if (drop_rsp) drop_q <= drop_q - CW'(1);
      if (issue) aq_wr_q <= aq_wr_q + PW'(1);
      if (rsp)   aq_rd_q <= aq_rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) aq_mem[aq_wr_q] <= pc_q;
  end

  // NOTE: only the output FIFO storage is reset, because instr/instr_pc must read zero out of reset;
  // the address queue is read only while outstanding > 0, so it carries no reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_q    <= '0;
      fifo_rd_q    <= '0;
      fifo_count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_word[i] <= '0;
      end
    end else if (redirect) begin
      fifo_wr_q    <= '0;
      fifo_rd_q    <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        fifo_pc[fifo_wr_q]   <= aq_mem[aq_rd_q];
        fifo_word[fifo_wr_q] <= imem_rdata;
        fifo_wr_q            <= fifo_wr_q + PW'(1);
      end
      if (pop) fifo_rd_q <= fifo_rd_q + PW'(1);
      fifo_count_q <= fifo_count_q + CW'(push) - CW'(pop);
    end
  end

  assign instr_valid = (fifo_count_q != '0);
  assign instr       = fifo_word[fifo_rd_q];
  assign instr_pc    = fifo_pc[fifo_rd_q];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state_q == RUN) && !instr_valid && !redirect_valid && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

`ifndef SYNTHESIS
  rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (outstanding_q == '0)));
`endif

endmodule
